// File: rtl/fetch_controller.sv
// fetch_controller: sequential instruction fetcher feeding a valid/ready consumer.
// It issues one PC per cycle to a memory with one-cycle read latency. A single-entry
// skid buffer holds the word that arrives while the consumer is stalled.
//
// Handshake: the inst/inst_pc word transfers on any cycle where inst_valid && inst_ready
// are both high at the rising edge. While inst_valid is high and no transfer has occurred,
// inst and inst_pc hold steady. A redirect or a reset is the only event that withdraws a
// word that was offered but not accepted.
module fetch_controller #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int unsigned PC_STEP   = 4,
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        busy,
  output logic [31:0] fetch_count,
  output logic [1:0]  dbg_state_o
);

  // Keep every PC inside the address space and word-aligned.
  localparam logic [31:0] PC_MASK = 32'(MEM_DEPTH - 1) & ~32'd3;
  localparam logic [31:0] STEP    = 32'(PC_STEP);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] count_q, count_d;
  logic        issue;
  logic        accept;

  assign dbg_state_o = state_q;
  assign fetch_count = count_q;

  // Output view: buffer first, then the word returning from memory. Reset and redirect
  // hide any word that is pending.
  always_comb begin
    imem_address = pc_q;
    inst_valid   = (buf_valid_q | inflight_q) & ~redirect_valid;
    busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
    if (buf_valid_q) begin
      inst    = buf_inst_q;
      inst_pc = buf_pc_q;
    end else if (inflight_q) begin
      inst    = imem_instruction;
      inst_pc = inflight_pc_q;
    end else begin
      inst    = buf_inst_q;
      inst_pc = buf_pc_q;
    end
    if (reset) begin
      imem_address = RESET_PC;
      inst_valid   = 1'b0;
      busy         = 1'b0;
      inst         = 32'h0;
      inst_pc      = 32'h0;
    end
  end

  // Datapath next state: issue, skid capture/release, redirect flush, acceptance count.
  always_comb begin
    issue         = (state_q == S_RUN) && !halt && !redirect_valid && !buf_valid_q &&
                    (!inflight_q || inst_ready);
    accept        = inst_valid & inst_ready;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    buf_valid_d   = buf_valid_q;
    buf_inst_d    = buf_inst_q;
    buf_pc_d      = buf_pc_q;
    count_d       = count_q + 32'(accept);
    if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
      pc_d          = (pc_q + STEP) & PC_MASK;
    end
    if (buf_valid_q && inst_ready) begin
      buf_valid_d = 1'b0;
    end else if (inflight_q && !buf_valid_q && !inst_ready) begin
      buf_valid_d = 1'b1;
      buf_inst_d  = imem_instruction;
      buf_pc_d    = inflight_pc_q;
    end
    if (redirect_valid) begin
      pc_d        = redirect_pc & PC_MASK;
      inflight_d  = 1'b0;
      buf_valid_d = 1'b0;
    end
  end

  // Control FSM next state; DRAIN ends once nothing is left in flight or buffered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALTED: if (start && !halt) state_d = S_RUN;
      S_RUN:            if (halt) state_d = redirect_valid ? S_HALTED : S_DRAIN;
      S_DRAIN:          if (!inflight_d && !buf_valid_d) state_d = S_HALTED;
      default:          state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers; reset discards anything in flight or buffered.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      buf_valid_q   <= 1'b0;
      buf_inst_q    <= 32'h0;
      buf_pc_q      <= 32'h0;
      count_q       <= 32'h0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      buf_valid_q   <= buf_valid_d;
      buf_inst_q    <= buf_inst_d;
      buf_pc_q      <= buf_pc_d;
      count_q       <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed cycle-by-cycle driver with point checks, plus a
// scoreboard monitor that pops {pc, word} on every accepted instruction.
module tb_fetch_controller;

  logic        clk;
  logic        reset;
  logic        start;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        busy;
  logic [31:0] fetch_count;
  logic [1:0]  dbg_state;

  localparam logic [31:0] ST_IDLE   = 32'd0;
  localparam logic [31:0] ST_DRAIN  = 32'd2;
  localparam logic [31:0] ST_HALTED = 32'd3;

  int tests;
  int fails;
  logic [63:0] exp_q[$];
  logic [31:0] mem[0:255];

  fetch_controller dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .halt             (halt),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .inst             (inst),
    .inst_pc          (inst_pc),
    .busy             (busy),
    .fetch_count      (fetch_count),
    .dbg_state_o      (dbg_state)
  );

  // Clock and memory model with one-cycle read latency.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
    mem[0] = 32'h2108_0008;
    mem[1] = 32'h2129_0009;
    mem[5] = 32'h8D28_0018;
    imem_instruction = 32'h0;
  end

  always @(posedge clk) imem_instruction <= mem[imem_address[9:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] word);
    exp_q.push_back({pc, word});
  endtask

  // Scoreboard monitor: every accepted word must be the next expected one.
  always @(negedge clk) begin
    if (inst_valid && inst_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL accept_unexpected: got pc %h inst %h with nothing expected", inst_pc, inst);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({inst_pc, inst} !== e) begin
          fails++;
          $display("FAIL accept_word: got pc %h inst %h expected pc %h inst %h",
                   inst_pc, inst, e[63:32], e[31:0]);
        end
      end
    end
  end

  // Directed driver.
  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1; start = 1'b0; halt = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b1;
    tick(); tick();
    settle();
    chk("rst_addr", imem_address, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    tick();
    reset = 1'b0;
    settle();
    chk("post_rst_state", 32'(dbg_state), ST_IDLE);
    chk("post_rst_count", fetch_count, 32'd0);
    chk("post_rst_addr", imem_address, 32'h0);
    chk("post_rst_valid", 32'(inst_valid), 32'd0);

    // Basic fetch, then redirect while pc 8 is in flight.
    push(32'd0, 32'h2108_0008);
    push(32'd4, 32'h2129_0009);
    push(32'd20, 32'h8D28_0018);
    start = 1'b1; tick();
    start = 1'b0; settle();
    chk("c2_addr", imem_address, 32'd0);
    chk("c2_valid", 32'(inst_valid), 32'd0);
    chk("c2_busy", 32'(busy), 32'd1);
    tick(); settle();
    chk("c3_addr", imem_address, 32'd4);
    chk("c3_valid", 32'(inst_valid), 32'd1);
    chk("c3_inst", inst, 32'h2108_0008);
    tick(); settle();
    chk("c4_addr", imem_address, 32'd8);
    chk("c4_inst_pc", inst_pc, 32'd4);
    tick(); settle();
    chk("c5_count", fetch_count, 32'd2);
    chk("c5_addr", imem_address, 32'd12);
    redirect_valid = 1'b1; redirect_pc = 32'd20; settle();
    chk("redir_valid_low", 32'(inst_valid), 32'd0);
    tick();
    redirect_valid = 1'b0; settle();
    chk("redir_addr20", imem_address, 32'd20);
    chk("redir_bubble", 32'(inst_valid), 32'd0);
    tick(); settle();
    chk("redir_word_pc", inst_pc, 32'd20);
    tick();
    reset = 1'b1; settle();
    chk("rst_mid_valid", 32'(inst_valid), 32'd0);
    tick();
    reset = 1'b0; settle();
    chk("rst_mid_state", 32'(dbg_state), ST_IDLE);
    chk("rst_mid_count", fetch_count, 32'd0);
    chk("rst_mid_addr", imem_address, 32'd0);

    // Consumer stall with pc 4 in flight.
    push(32'd0, 32'h2108_0008);
    push(32'd4, 32'h2129_0009);
    push(32'd8, 32'hA500_0002);
    start = 1'b1; tick();
    start = 1'b0; tick();
    settle();
    chk("s_pc0", inst_pc, 32'd0);
    tick();
    inst_ready = 1'b0; settle();
    chk("s_valid", 32'(inst_valid), 32'd1);
    chk("s_inst_pc", inst_pc, 32'd4);
    for (int k = 0; k < 2; k++) begin
      tick(); settle();
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_inst_pc", inst_pc, 32'd4);
      chk("stall_inst", inst, 32'h2129_0009);
      chk("stall_addr", imem_address, 32'd8);
    end
    tick();
    inst_ready = 1'b1; settle();
    chk("release_pc", inst_pc, 32'd4);
    chk("release_addr", imem_address, 32'd8);
    tick(); settle();
    chk("release_bubble", 32'(inst_valid), 32'd0);
    chk("reissue_addr", imem_address, 32'd8);
    tick(); settle();
    chk("pc8_delivered", inst_pc, 32'd8);

    // Redirect near the top of the address space and a misaligned redirect.
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'd1020; tick();
    redirect_valid = 1'b0; settle();
    chk("addr_1020", imem_address, 32'd1020);
    push(32'd1020, 32'hA500_00FF);
    tick(); settle();
    chk("wrap_addr0", imem_address, 32'd0);
    chk("wrap_word_pc", inst_pc, 32'd1020);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0403; settle();
    chk("redir2_valid_low", 32'(inst_valid), 32'd0);
    tick();
    redirect_valid = 1'b0; settle();
    chk("misaligned_addr", imem_address, 32'd0);
    push(32'd0, 32'h2108_0008);

    // Halt with a stalled word in flight: drain, halt, then resume.
    tick();
    inst_ready = 1'b0; halt = 1'b1; settle();
    chk("halt_valid", 32'(inst_valid), 32'd1);
    tick();
    halt = 1'b0; settle();
    chk("drain_state", 32'(dbg_state), ST_DRAIN);
    chk("drain_busy", 32'(busy), 32'd1);
    chk("drain_inst_pc", inst_pc, 32'd0);
    chk("drain_addr", imem_address, 32'd4);
    tick();
    inst_ready = 1'b1; settle();
    chk("drain_busy2", 32'(busy), 32'd1);
    tick(); settle();
    chk("halted_state", 32'(dbg_state), ST_HALTED);
    chk("halted_busy", 32'(busy), 32'd0);
    chk("halted_valid", 32'(inst_valid), 32'd0);
    chk("halted_addr", imem_address, 32'd4);
    push(32'd4, 32'h2129_0009);
    start = 1'b1; tick();
    start = 1'b0; settle();
    chk("resume_addr", imem_address, 32'd4);
    chk("resume_busy", 32'(busy), 32'd1);
    tick(); settle();
    chk("resume_word_pc", inst_pc, 32'd4);

    // Redirect together with halt goes straight to HALTED; start+halt and halt are ignored there.
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'd40; halt = 1'b1; settle();
    chk("rh_valid_low", 32'(inst_valid), 32'd0);
    tick();
    redirect_valid = 1'b0; halt = 1'b0; settle();
    chk("rh_state", 32'(dbg_state), ST_HALTED);
    chk("rh_busy", 32'(busy), 32'd0);
    chk("rh_addr", imem_address, 32'd40);
    start = 1'b1; halt = 1'b1; tick();
    start = 1'b0; halt = 1'b0; settle();
    chk("start_halt_ignored", 32'(dbg_state), ST_HALTED);
    halt = 1'b1; tick();
    halt = 1'b0; settle();
    chk("halt_in_halted", 32'(dbg_state), ST_HALTED);
    chk("count_before_rst", fetch_count, 32'd6);

    // Reset while a word sits in the skid buffer.
    start = 1'b1; tick();
    start = 1'b0; settle();
    chk("run40_addr", imem_address, 32'd40);
    tick();
    inst_ready = 1'b0; tick();
    settle();
    chk("buf_valid", 32'(inst_valid), 32'd1);
    chk("buf_inst_pc", inst_pc, 32'd40);
    chk("buf_inst", inst, 32'hA500_000A);
    reset = 1'b1; tick();
    reset = 1'b0; inst_ready = 1'b1; settle();
    chk("rbuf_state", 32'(dbg_state), ST_IDLE);
    chk("rbuf_valid", 32'(inst_valid), 32'd0);
    chk("rbuf_count", fetch_count, 32'd0);
    chk("rbuf_addr", imem_address, 32'd0);
    chk("rbuf_inst", inst, 32'h0);
    chk("rbuf_inst_pc", inst_pc, 32'h0);
    tick(); tick(); tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
